// File: rtl/bsg_test_master_multi_ch_pkg.sv
// Shared types for the multi-channel DRAM traffic generator: per-channel
// FSM states, the request struct typedef macro and a safe clog2 helper.
`ifndef BSG_TMMC_REQ_S
`define BSG_TMMC_REQ_S
`define BSG_TMMC_REQ_STRUCT(aw) struct packed { logic write_not_read; logic [(aw)-1:0] ch_addr; }
`endif

package bsg_test_master_multi_ch_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } ch_state_e;

    // Width of an index over x items; never returns 0 so x==1 still yields a port.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_test_master_multi_ch_if.sv
// Request stream and per-channel DRAM handshake bundle of the test master.
interface bsg_test_master_multi_ch_if
    import bsg_test_master_multi_ch_pkg::*;
#(
    parameter int num_channels_p       = 8,
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 256
);
    localparam int id_width_lp = safe_clog2(num_channels_p);

    logic                                                   v_i;
    logic [id_width_lp-1:0]                                 ch_id_i;
    logic                                                   write_not_read_i;
    logic [channel_addr_width_p-1:0]                        ch_addr_i;
    logic                                                   yumi_o;
    logic [num_channels_p-1:0]                              dram_v_o;
    logic [num_channels_p-1:0]                              dram_write_not_read_o;
    logic [num_channels_p-1:0][channel_addr_width_p-1:0]    dram_ch_addr_o;
    logic [num_channels_p-1:0]                              dram_yumi_i;
    logic [num_channels_p-1:0]                              dram_data_v_o;
    logic [num_channels_p-1:0][data_width_p-1:0]            dram_data_o;
    logic [num_channels_p-1:0]                              dram_data_yumi_i;
    logic [num_channels_p-1:0]                              dram_data_v_i;

    modport master (
        input  v_i, ch_id_i, write_not_read_i, ch_addr_i,
        input  dram_yumi_i, dram_data_yumi_i, dram_data_v_i,
        output yumi_o, dram_v_o, dram_write_not_read_o, dram_ch_addr_o,
        output dram_data_v_o, dram_data_o
    );

    modport slave (
        output v_i, ch_id_i, write_not_read_i, ch_addr_i,
        output dram_yumi_i, dram_data_yumi_i, dram_data_v_i,
        input  yumi_o, dram_v_o, dram_write_not_read_o, dram_ch_addr_o,
        input  dram_data_v_o, dram_data_o
    );
endinterface

// File: rtl/bsg_test_master_multi_ch_ch.sv
// One DRAM channel: request holding register, EMPTY/REQ/WDATA FSM, read
// credit counter and saturating statistics counters.
module bsg_test_master_ch
    import bsg_test_master_multi_ch_pkg::*;
#(
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 256,
    parameter int max_outstanding_p    = 4,
    parameter int counter_width_p      = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            i_v,
    input  logic                            i_write_not_read,
    input  logic [channel_addr_width_p-1:0] i_ch_addr,
    output logic                            o_ready,
    output logic                            o_dram_v,
    output logic                            o_dram_write_not_read,
    output logic [channel_addr_width_p-1:0] o_dram_ch_addr,
    input  logic                            i_dram_yumi,
    output logic                            o_dram_data_v,
    output logic [data_width_p-1:0]         o_dram_data,
    input  logic                            i_dram_data_yumi,
    input  logic                            i_dram_data_v,
    output logic [counter_width_p-1:0]      o_read_issued,
    output logic [counter_width_p-1:0]      o_write_issued,
    output logic [counter_width_p-1:0]      o_read_returned,
    output logic                            o_idle
);
    localparam int credit_width_lp = safe_clog2(max_outstanding_p + 1);
    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_outstanding_p);

    typedef `BSG_TMMC_REQ_STRUCT(channel_addr_width_p) req_s;

    ch_state_e                   r_state, w_state_nxt;
    req_s                        r_req, w_req_nxt;
    logic [credit_width_lp-1:0]  r_credit, w_credit_nxt;
    logic                        r_dram_v, r_data_v;
    logic [counter_width_p-1:0]  r_read_issued, r_write_issued, r_read_returned;
    logic                        w_read_yumi, w_write_yumi, w_data_done, w_capture;

    function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] c,
                                                           input logic en);
        return (en && (c != '1)) ? c + counter_width_p'(1) : c;
    endfunction

    assign w_read_yumi  = r_dram_v & i_dram_yumi & ~r_req.write_not_read;
    assign w_write_yumi = r_dram_v & i_dram_yumi &  r_req.write_not_read;
    assign w_data_done  = r_data_v & i_dram_data_yumi;
    // A read leaving REQ frees the holding register in the same cycle.
    assign o_ready      = (r_state == EMPTY) | w_read_yumi;
    assign w_capture    = i_v & o_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        if (w_capture) begin
            w_state_nxt              = REQ;
            w_req_nxt.write_not_read = i_write_not_read;
            w_req_nxt.ch_addr        = i_ch_addr;
        end else if (w_read_yumi || w_data_done) begin
            w_state_nxt = EMPTY;
        end else if (w_write_yumi) begin
            w_state_nxt = WDATA;
        end

        w_credit_nxt = r_credit;
        if (w_read_yumi && !i_dram_data_v)
            w_credit_nxt = r_credit - credit_width_lp'(1);
        else if (!w_read_yumi && i_dram_data_v && (r_credit != credit_max_lp))
            w_credit_nxt = r_credit + credit_width_lp'(1);
    end

    // Handshake valids are registered from the next state so they are glitch-free.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state         <= EMPTY;
            r_req           <= '0;
            r_credit        <= credit_max_lp;
            r_dram_v        <= 1'b0;
            r_data_v        <= 1'b0;
            r_read_issued   <= '0;
            r_write_issued  <= '0;
            r_read_returned <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_req           <= w_req_nxt;
            r_credit        <= w_credit_nxt;
            r_dram_v        <= (w_state_nxt == REQ) &&
                               (w_req_nxt.write_not_read || (w_credit_nxt != '0));
            r_data_v        <= (w_state_nxt == WDATA);
            r_read_issued   <= sat_inc(r_read_issued, w_read_yumi);
            r_write_issued  <= sat_inc(r_write_issued, w_data_done);
            r_read_returned <= sat_inc(r_read_returned, i_dram_data_v);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(i_dram_data_v && (r_credit == credit_max_lp)))
                else $error("read return with no read outstanding (credit underflow)");
    end

    assign o_dram_v              = r_dram_v;
    assign o_dram_write_not_read = r_req.write_not_read;
    assign o_dram_ch_addr        = r_req.ch_addr;
    assign o_dram_data_v         = r_data_v;
    assign o_dram_data           = data_width_p'(r_req.ch_addr);
    assign o_read_issued         = r_read_issued;
    assign o_write_issued        = r_write_issued;
    assign o_read_returned       = r_read_returned;
    assign o_idle                = (r_state == EMPTY) && (r_credit == credit_max_lp);
endmodule

// File: rtl/bsg_test_master_multi_ch.sv
// Multi-channel DRAM traffic generator: routes a request stream to per-channel
// engines and tracks busy cycles and completion.
module bsg_test_master_multi_ch
    import bsg_test_master_multi_ch_pkg::*;
#(
    parameter int num_channels_p       = 8,
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 256,
    parameter int max_outstanding_p    = 4,
    parameter int counter_width_p      = 32
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    bsg_test_master_multi_ch_if.master                 bus,
    output logic [num_channels_p-1:0][counter_width_p-1:0] read_issued_o,
    output logic [num_channels_p-1:0][counter_width_p-1:0] write_issued_o,
    output logic [num_channels_p-1:0][counter_width_p-1:0] read_returned_o,
    output logic [counter_width_p-1:0]                 busy_cycles_o,
    output logic                                       done_o
);
    localparam int id_width_lp = safe_clog2(num_channels_p);

    logic [num_channels_p-1:0]                            w_sel, w_ready, w_idle;
    logic [num_channels_p-1:0]                            w_dram_v, w_dram_wnr, w_data_v;
    logic [num_channels_p-1:0][channel_addr_width_p-1:0]  w_dram_addr;
    logic [num_channels_p-1:0][data_width_p-1:0]          w_dram_data;
    logic [counter_width_p-1:0]                           r_busy_cycles;
    logic                                                 w_busy;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        assign w_sel[c] = bus.v_i && (bus.ch_id_i == id_width_lp'(c));

        bsg_test_master_ch #(
            .channel_addr_width_p (channel_addr_width_p),
            .data_width_p         (data_width_p),
            .max_outstanding_p    (max_outstanding_p),
            .counter_width_p      (counter_width_p)
        ) u_ch (
            .clk_i                 (clk_i),
            .reset_i               (reset_i),
            .i_v                   (w_sel[c]),
            .i_write_not_read      (bus.write_not_read_i),
            .i_ch_addr             (bus.ch_addr_i),
            .o_ready               (w_ready[c]),
            .o_dram_v              (w_dram_v[c]),
            .o_dram_write_not_read (w_dram_wnr[c]),
            .o_dram_ch_addr        (w_dram_addr[c]),
            .i_dram_yumi           (bus.dram_yumi_i[c]),
            .o_dram_data_v         (w_data_v[c]),
            .o_dram_data           (w_dram_data[c]),
            .i_dram_data_yumi      (bus.dram_data_yumi_i[c]),
            .i_dram_data_v         (bus.dram_data_v_i[c]),
            .o_read_issued         (read_issued_o[c]),
            .o_write_issued        (write_issued_o[c]),
            .o_read_returned       (read_returned_o[c]),
            .o_idle                (w_idle[c])
        );
    end

    // An id that matches no channel selects nothing, so it is never consumed.
    assign bus.yumi_o                = |(w_sel & w_ready);
    assign bus.dram_v_o              = w_dram_v;
    assign bus.dram_write_not_read_o = w_dram_wnr;
    assign bus.dram_ch_addr_o        = w_dram_addr;
    assign bus.dram_data_v_o         = w_data_v;
    assign bus.dram_data_o           = w_dram_data;

    assign w_busy        = ~&w_idle;
    assign done_o        = ~bus.v_i & (&w_idle);
    assign busy_cycles_o = r_busy_cycles;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_busy_cycles <= '0;
        else if (w_busy && (r_busy_cycles != '1))
            r_busy_cycles <= r_busy_cycles + counter_width_p'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(bus.v_i && !(|w_sel)))
                else $error("request to nonexistent channel id %0d", bus.ch_id_i);
    end
endmodule
